// File: rtl/onehot_assembler.sv
// rtl/onehot_assembler.sv - rebuilds a bit vector from a framed stream of one-hot beats
module onehot_assembler #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_last_i,
  input  logic             data_val_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] data_cnt_o,
  output logic             data_err_o,
  output logic             data_val_o,
  output logic             busy_o
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [WIDTH-1:0] DATA_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, beat_acc;
  logic [CNT_W-1:0] cnt_q, cnt_d, beat_cnt;
  logic             err_q, err_d, beat_err;
  logic             beat_nz, beat_onehot, beat_overlap, frame_done;

  // Post-beat view of the frame; also what gets published when the beat is last.
  always_comb begin
    beat_nz      = |data_i;
    beat_onehot  = beat_nz && ((data_i & (data_i - DATA_ONE)) == '0);
    beat_overlap = |(acc_q & data_i);
    beat_acc     = acc_q;
    beat_cnt     = cnt_q;
    beat_err     = err_q;
    if (data_val_i && beat_nz) begin
      beat_acc = acc_q | data_i;
      if (cnt_q != CNT_MAX) beat_cnt = cnt_q + CNT_ONE;
      beat_err = err_q | ~beat_onehot | beat_overlap;
    end
  end

  always_comb begin
    frame_done = data_val_i && data_last_i;
    state_d    = state_q;
    acc_d      = beat_acc;
    cnt_d      = beat_cnt;
    err_d      = beat_err;
    if (frame_done) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (data_val_i) begin
      state_d = COLLECT;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Result registers hold until the next frame completes; only the valid strobe pulses.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o     <= '0;
      data_cnt_o <= '0;
      data_err_o <= 1'b0;
      data_val_o <= 1'b0;
    end else begin
      data_val_o <= frame_done;
      if (frame_done) begin
        data_o     <= beat_acc;
        data_cnt_o <= beat_cnt;
        data_err_o <= beat_err;
      end
    end
  end

  assign busy_o = (state_q == COLLECT);

endmodule

// File: tb/tb_onehot_assembler.sv
// tb/tb_onehot_assembler.sv - scoreboard bench for onehot_assembler
module tb_onehot_assembler;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } frame_t;

  logic             clk_i = 1'b0;
  logic             arst_n_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             data_last_i = 1'b0;
  logic             data_val_i = 1'b0;
  logic [WIDTH-1:0] data_o;
  logic [CNT_W-1:0] data_cnt_o;
  logic             data_err_o;
  logic             data_val_o;
  logic             busy_o;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  onehot_assembler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .data_i     (data_i),
    .data_last_i(data_last_i),
    .data_val_i (data_val_i),
    .data_o     (data_o),
    .data_cnt_o (data_cnt_o),
    .data_err_o (data_err_o),
    .data_val_o (data_val_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic push_exp(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c, input logic e);
    frame_t f;
    f.data = d;
    f.cnt  = c;
    f.err  = e;
    exp_q.push_back(f);
  endtask

  // Applies one cycle of input, then scores the registered result one edge later.
  task automatic drive_beat(input logic v, input logic [WIDTH-1:0] d, input logic l);
    frame_t f;
    data_val_i  = v;
    data_i      = d;
    data_last_i = l;
    @(posedge clk_i);
    #1;
    data_val_i  = 1'b0;
    data_i      = '0;
    data_last_i = 1'b0;
    checks++;
    if (data_val_o !== (v && l)) begin
      errors++;
      $display("FAIL val_pulse: got %b want %b", data_val_o, v && l);
    end
    if (data_val_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got data_val_o=1 want no frame");
      end else begin
        f = exp_q.pop_front();
        checks++;
        if (data_o !== f.data) begin
          errors++;
          $display("FAIL frame_data: got %b want %b", data_o, f.data);
        end
        checks++;
        if (data_cnt_o !== f.cnt) begin
          errors++;
          $display("FAIL frame_cnt: got %0d want %0d", data_cnt_o, f.cnt);
        end
        checks++;
        if (data_err_o !== f.err) begin
          errors++;
          $display("FAIL frame_err: got %b want %b", data_err_o, f.err);
        end
      end
    end
  endtask

  task automatic test_reset;
    arst_n_i = 1'b0;
    #3;
    checks++;
    if ({data_o, data_cnt_o, data_err_o, data_val_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {data_o, data_cnt_o, data_err_o, data_val_o, busy_o});
    end
    @(posedge clk_i);
    #1;
    arst_n_i = 1'b1;
  endtask

  task automatic test_basic;
    push_exp(4'b1101, 3'd3, 1'b0);
    drive_beat(1'b1, 4'b0001, 1'b0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_first: got %b want 1", busy_o);
    end
    drive_beat(1'b1, 4'b0100, 1'b0);
    drive_beat(1'b1, 4'b1000, 1'b1);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_last: got %b want 0", busy_o);
    end
    drive_beat(1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_back_to_back;
    push_exp(4'b0010, 3'd1, 1'b0);
    push_exp(4'b0000, 3'd0, 1'b0);
    push_exp(4'b1000, 3'd1, 1'b0);
    drive_beat(1'b1, 4'b0010, 1'b1);
    drive_beat(1'b1, 4'b0000, 1'b1);
    drive_beat(1'b1, 4'b1000, 1'b1);
    drive_beat(1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_duplicate;
    push_exp(4'b0100, 3'd2, 1'b1);
    push_exp(4'b0001, 3'd1, 1'b0);
    drive_beat(1'b1, 4'b0100, 1'b0);
    drive_beat(1'b1, 4'b0100, 1'b1);
    drive_beat(1'b1, 4'b0001, 1'b1);
  endtask

  task automatic test_multihot;
    push_exp(4'b0110, 3'd1, 1'b1);
    drive_beat(1'b1, 4'b0110, 1'b1);
  endtask

  task automatic test_gaps;
    push_exp(4'b0011, 3'd2, 1'b0);
    drive_beat(1'b1, 4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_beat(1'b0, 4'b1111, 1'b1);
      checks++;
      if (data_o !== 4'b0110 || data_cnt_o !== 3'd1 || data_err_o !== 1'b1 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL gap_hold: got data=%b cnt=%0d err=%b busy=%b want 0110/1/1/1",
                 data_o, data_cnt_o, data_err_o, busy_o);
      end
    end
    drive_beat(1'b1, 4'b0010, 1'b1);
  endtask

  task automatic test_saturation;
    push_exp(4'b0001, 3'd7, 1'b1);
    for (int i = 0; i < 9; i++) drive_beat(1'b1, 4'b0001, 1'b0);
    drive_beat(1'b1, 4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid_frame;
    push_exp(4'b0001, 3'd1, 1'b0);
    drive_beat(1'b1, 4'b1000, 1'b0);
    drive_beat(1'b1, 4'b0100, 1'b0);
    #2;
    arst_n_i = 1'b0;
    #1;
    checks++;
    if ({data_o, data_cnt_o, data_err_o, data_val_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_frame: got %b want 0", {data_o, data_cnt_o, data_err_o, data_val_o, busy_o});
    end
    #2;
    arst_n_i = 1'b1;
    drive_beat(1'b1, 4'b0001, 1'b1);
    drive_beat(1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_duplicate();
    test_multihot();
    test_gaps();
    test_saturation();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_missing: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_assembler.md
# onehot_assembler

Reassembles a bit vector from a stream of one-hot beats, the inverse of priority encoding: each beat carries one isolated set bit (as produced by left/right priority isolation), and a frame of beats is ORed back into the original vector. It sits downstream of priority-encoding and grant logic and rebuilds the request/grant mask. It also reports the beat count and flags malformed frames. It has no backpressure.

## Interface
- WIDTH, 4, vector width; ≥ 2
- CNT_W, $clog2(WIDTH+1), width of beat counter output
- clk_i  in  1  clock; all logic on rising edge
- arst_n_i  in  1  reset, asynchronous assert, active-low; one clock, reset asynchronous active-low
- data_i  in  WIDTH  beat payload; expected one-hot or all-zero
- data_last_i  in  1  qualifies beat as final beat of frame
- data_val_i  in  1  beat valid; data_i/data_last_i ignored when 0
- data_o  out  WIDTH  assembled vector of last completed frame
- data_cnt_o  out  CNT_W  number of nonzero beats in last completed frame, saturating at 2^CNT_W-1
- data_err_o  out  1  last completed frame was malformed
- data_val_o  out  1  single-cycle pulse: data_o/data_cnt_o/data_err_o updated
- busy_o  out  1  a frame is partially collected

## Operation
- States: IDLE (no beats held) and COLLECT (≥1 non-last beat accepted). busy_o = (state == COLLECT).
- Internal: acc[WIDTH], cnt[CNT_W], err; all cleared in IDLE.
- Per valid beat, with onehot = data_i has exactly one bit set, zero = data_i == 0:
  - zero: legal, no change to acc/cnt (encodes empty vector or idle slot).
  - onehot and (acc & data_i) == 0: acc |= data_i; cnt += 1 (saturating).
  - onehot and bit already in acc: duplicate → err = 1; cnt += 1; acc unchanged.
  - multi-hot (≥2 bits): err = 1; acc |= data_i; cnt += 1.
- Non-last valid beat: IDLE→COLLECT, or stay COLLECT.
- Last valid beat (from IDLE or COLLECT): outputs load the post-beat values (acc', cnt', err' including this beat); data_val_o = 1 next cycle; internal state cleared; → IDLE. A single-beat frame (last on first beat) is legal.
- Back-to-back frames: a new frame's first beat is accepted the cycle immediately after a last beat, no bubble.
- data_val_i = 0: no state change; gaps inside a frame are allowed indefinitely.
- Output registers hold their value until the next frame completes; only data_val_o pulses.

## Timing
- Latency: last beat at edge N → data_o/data_cnt_o/data_err_o valid and data_val_o = 1 after edge N, for exactly one cycle of data_val_o.
- Throughput: one beat per cycle; one frame per cycle for single-beat frames (data_val_o high continuously).
- Reset (arst_n_i = 0, any time): immediately data_o = 0, data_cnt_o = 0, data_err_o = 0, data_val_o = 0, busy_o = 0, state IDLE, acc/cnt/err = 0. A partial frame is discarded, never emitted. First beat accepted on the first rising edge with arst_n_i = 1.
- Counter saturation: cnt stops at 2^CNT_W-1 (reachable only with duplicates/zero-free long erroneous frames); err is already set in that case.
- All outputs registered; no combinational input→output path.

## Test plan
- WIDTH=4: beats 0001, 0100, 1000(last) → one cycle later data_o=1101, data_cnt_o=3, data_err_o=0, data_val_o pulse 1 cycle; busy_o=1 after first beat, 0 after last.
- Single-beat frames on consecutive cycles: 0010(last), 0000(last), 1000(last) → data_val_o high 3 cycles; data_o = 0010, 0000, 1000; cnt = 1, 0, 1; err = 0.
- Duplicate: 0100, 0100(last) → data_o=0100, data_cnt_o=2, data_err_o=1; next frame 0001(last) → data_err_o=0 (err does not persist).
- Multi-hot: 0110(last) → data_o=0110, data_cnt_o=1, data_err_o=1.
- Gaps: 0001, idle 5 cycles, 0010(last) → data_o=0011, cnt=2; no data_val_o during gap; outputs hold previous frame values throughout.
- Reset mid-frame: 1000, 0100, assert arst_n_i between edges → all outputs 0 immediately; after release, 0001(last) → data_o=0001, cnt=1 (no residue from discarded frame).
